// File: rtl/io_bus_pkg.sv
// Shared types and constants for blocks on the I/O page of the CPU memory bus.
package io_bus_pkg;

   typedef logic [3:0] nibble_t;

   localparam logic [3:0] IO_PAGE             = 4'hF;
   localparam logic [7:0] DEFAULT_FACTOR_BASE = 8'h00;
   localparam logic [7:0] DEFAULT_MASK_BASE   = 8'h10;
   localparam int         MAX_GROUPS          = 16;

endpackage

// File: rtl/io_factor_bank_channel.sv
// One 4-bit interrupt-factor channel: edge capture, sticky factor flags with
// read/write-1 clear, a mask register and a registered masked request.
module factor_channel
   import io_bus_pkg::*;
(
   input  logic    clk,
   input  logic    reset_n,
   input  nibble_t event_in,
   input  logic    factor_read,
   input  logic    factor_write,
   input  logic    mask_write,
   input  nibble_t write_data,
   output nibble_t factor,
   output nibble_t mask,
   output logic    interrupt_req
);

   nibble_t event_prev;
   nibble_t rise;
   nibble_t factor_next;
   nibble_t mask_next;

   // Rise is ORed in after any clear so a new edge is never lost to a clear.
   always_comb begin
      rise = event_in & ~event_prev;
      if (factor_read) begin
         factor_next = rise;
      end else if (factor_write) begin
         factor_next = (factor & ~write_data) | rise;
      end else begin
         factor_next = factor | rise;
      end
      mask_next = mask_write ? write_data : mask;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         event_prev    <= '0;
         factor        <= '0;
         mask          <= '0;
         interrupt_req <= 1'b0;
      end else begin
         event_prev    <= event_in;
         factor        <= factor_next;
         mask          <= mask_next;
         interrupt_req <= |(factor_next & mask_next);
      end
   end

endmodule

// File: rtl/io_factor_bank.sv
// Interrupt-factor register bank on the I/O page: GROUPS factor channels with
// address decode and a registered one-cycle-latency read port.
module io_factor_bank
   import io_bus_pkg::*;
#(
   parameter int          GROUPS      = 4,
   parameter logic [7:0]  FACTOR_BASE = DEFAULT_FACTOR_BASE,
   parameter logic [7:0]  MASK_BASE   = DEFAULT_MASK_BASE
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  bus_sel,
   input  logic [7:0]            bus_addr,
   input  logic                  bus_write_en,
   input  logic [3:0]            bus_write_data,
   output logic [3:0]            bus_read_data,
   output logic                  bus_hit,
   input  logic [4*GROUPS-1:0]   event_in,
   output logic [GROUPS-1:0]     interrupt_req
);

   if (GROUPS < 1 || GROUPS > MAX_GROUPS) begin : g_bad_groups
      $error("io_factor_bank: GROUPS must be within 1..MAX_GROUPS");
   end

   if ((int'(FACTOR_BASE) < int'(MASK_BASE) + GROUPS) &&
       (int'(MASK_BASE) < int'(FACTOR_BASE) + GROUPS)) begin : g_overlap
      $error("io_factor_bank: factor and mask address windows overlap");
   end

   logic              read_access;
   logic              write_access;
   logic [GROUPS-1:0] factor_sel;
   logic [GROUPS-1:0] mask_sel;
   nibble_t           factor_q [GROUPS];
   nibble_t           mask_q   [GROUPS];
   nibble_t           read_value;
   logic              any_sel;

   assign read_access  = bus_sel & ~bus_write_en;
   assign write_access = bus_sel & bus_write_en;

   // Address compare is done 9 bits wide so a window near the top of the page
   // cannot wrap around onto low offsets.
   for (genvar g = 0; g < GROUPS; g++) begin : g_channel
      localparam logic [8:0] FACTOR_ADDR = 9'(FACTOR_BASE) + 9'(g);
      localparam logic [8:0] MASK_ADDR   = 9'(MASK_BASE) + 9'(g);

      assign factor_sel[g] = ({1'b0, bus_addr} == FACTOR_ADDR);
      assign mask_sel[g]   = ({1'b0, bus_addr} == MASK_ADDR);

      factor_channel u_channel (
         .clk           (clk),
         .reset_n       (reset_n),
         .event_in      (event_in[4*g +: 4]),
         .factor_read   (read_access & factor_sel[g]),
         .factor_write  (write_access & factor_sel[g]),
         .mask_write    (write_access & mask_sel[g]),
         .write_data    (bus_write_data),
         .factor        (factor_q[g]),
         .mask          (mask_q[g]),
         .interrupt_req (interrupt_req[g])
      );
   end

   // Factor data is taken from the pre-update register, so a read returns
   // exactly the flags it clears.
   always_comb begin
      read_value = '0;
      any_sel    = (|factor_sel) | (|mask_sel);
      for (int g = 0; g < GROUPS; g++) begin
         if (factor_sel[g]) begin
            read_value = read_value | factor_q[g];
         end
         if (mask_sel[g]) begin
            read_value = read_value | mask_q[g];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus_read_data <= '0;
         bus_hit       <= 1'b0;
      end else begin
         bus_hit       <= bus_sel & any_sel;
         bus_read_data <= (read_access & any_sel) ? read_value : '0;
      end
   end

endmodule

// File: tb/tb_io_factor_bank.sv
// Directed bench for io_factor_bank: expected read responses are queued when an
// access is driven and compared when the registered response appears.
module tb_io_factor_bank;

   localparam int GROUPS = 4;

   logic                clk;
   logic                reset_n;
   logic                bus_sel;
   logic [7:0]          bus_addr;
   logic                bus_write_en;
   logic [3:0]          bus_write_data;
   logic [3:0]          bus_read_data;
   logic                bus_hit;
   logic [4*GROUPS-1:0] event_in;
   logic [GROUPS-1:0]   interrupt_req;

   logic [4:0] expQueue [$];
   int total;
   int bad;

   io_factor_bank #(
      .GROUPS      (GROUPS),
      .FACTOR_BASE (8'h00),
      .MASK_BASE   (8'h10)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .bus_sel        (bus_sel),
      .bus_addr       (bus_addr),
      .bus_write_en   (bus_write_en),
      .bus_write_data (bus_write_data),
      .bus_read_data  (bus_read_data),
      .bus_hit        (bus_hit),
      .event_in       (event_in),
      .interrupt_req  (interrupt_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the directed sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkValue(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
         $error("[TB] %s mismatch", tag);
      end
   endtask

   task automatic applyStimulus(input logic sel, input logic we, input logic [7:0] addr,
                                input logic [3:0] wdata, input logic expHit,
                                input logic [3:0] expData);
      bus_sel        = sel;
      bus_write_en   = we;
      bus_addr       = addr;
      bus_write_data = wdata;
      expQueue.push_back({expHit, expData});
   endtask

   task automatic checkOutput(input string tag);
      logic [4:0] expected;
      total++;
      if (expQueue.size() == 0) begin
         bad++;
         $display("[TB] FAIL %s: observed=response expected=queued entry", tag);
      end else begin
         expected = expQueue.pop_front();
         assert ({bus_hit, bus_read_data} === expected) else begin
            bad++;
            $display("[TB] FAIL %s: observed hit/data=%b/%h expected=%b/%h",
                     tag, bus_hit, bus_read_data, expected[4], expected[3:0]);
            $error("[TB] %s mismatch", tag);
         end
      end
   endtask

   task automatic access(input string tag, input logic sel, input logic we,
                         input logic [7:0] addr, input logic [3:0] wdata,
                         input logic expHit, input logic [3:0] expData);
      @(negedge clk);
      applyStimulus(sel, we, addr, wdata, expHit, expData);
      @(negedge clk);
      checkOutput(tag);
      bus_sel = 1'b0;
   endtask

   task automatic setEvents(input logic [4*GROUPS-1:0] value);
      @(negedge clk);
      event_in = value;
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      reset_n        = 1'b0;
      bus_sel        = 1'b0;
      bus_write_en   = 1'b0;
      bus_addr       = 8'h00;
      bus_write_data = 4'h0;
      event_in       = '1;

      // Reset state with sources high
      #23;
      checkValue("reset_data", 16'(bus_read_data), 16'h0);
      checkValue("reset_hit", 16'(bus_hit), 16'h0);
      checkValue("reset_irq", 16'(interrupt_req), 16'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // First-edge rule: every factor captured, masks still zero
      access("first_read_g0", 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 4'hF);
      access("first_read_g1", 1'b1, 1'b0, 8'h01, 4'h0, 1'b1, 4'hF);
      access("first_read_g2", 1'b1, 1'b0, 8'h02, 4'h0, 1'b1, 4'hF);
      access("first_read_g3", 1'b1, 1'b0, 8'h03, 4'h0, 1'b1, 4'hF);
      checkValue("irq_masked_off", 16'(interrupt_req), 16'h0);
      setEvents('0);
      access("falling_no_set", 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 4'h0);

      // Read-to-clear
      setEvents(16'h0002);
      setEvents(16'h0000);
      access("rtc_first", 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 4'h2);
      access("rtc_second", 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 4'h0);

      // Masking
      access("mask_wr_g1_zero", 1'b1, 1'b1, 8'h11, 4'h0, 1'b1, 4'h0);
      setEvents(16'h0010);
      setEvents(16'h0000);
      checkValue("irq_masked_g1", 16'(interrupt_req), 16'h0);
      access("mask_wr_g1_one", 1'b1, 1'b1, 8'h11, 4'h1, 1'b1, 4'h0);
      checkValue("irq_after_mask", 16'(interrupt_req), 16'h2);
      access("factor_g1_read", 1'b1, 1'b0, 8'h01, 4'h0, 1'b1, 4'h1);
      checkValue("irq_after_clear", 16'(interrupt_req), 16'h0);
      access("mask_g1_read", 1'b1, 1'b0, 8'h11, 4'h0, 1'b1, 4'h1);

      // Simultaneous set and clear on group 0
      access("mask_wr_g0", 1'b1, 1'b1, 8'h10, 4'hF, 1'b1, 4'h0);
      setEvents(16'h0001);
      setEvents(16'h0000);
      checkValue("irq_g0_set", 16'(interrupt_req), 16'h1);
      @(negedge clk);
      event_in = 16'h0004;
      applyStimulus(1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 4'h1);
      @(negedge clk);
      checkOutput("setclr_read");
      bus_sel  = 1'b0;
      event_in = 16'h0000;
      checkValue("irq_g0_kept", 16'(interrupt_req), 16'h1);
      access("setclr_after", 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 4'h4);
      checkValue("irq_g0_drop", 16'(interrupt_req), 16'h0);

      // Write-1-to-clear and out-of-range addresses
      setEvents(16'h0F00);
      setEvents(16'h0000);
      access("w1c_write", 1'b1, 1'b1, 8'h02, 4'h5, 1'b1, 4'h0);
      access("w1c_read", 1'b1, 1'b0, 8'h02, 4'h0, 1'b1, 4'hA);
      access("oor_factor", 1'b1, 1'b0, 8'h04, 4'h0, 1'b0, 4'h0);
      access("oor_mask", 1'b1, 1'b0, 8'h14, 4'h0, 1'b0, 4'h0);
      access("oor_write", 1'b1, 1'b1, 8'h05, 4'hF, 1'b0, 4'h0);
      access("not_selected", 1'b0, 1'b0, 8'h10, 4'h0, 1'b0, 4'h0);

      // Back-to-back reads every cycle
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 8'h10, 4'h0, 1'b1, 4'hF);
      @(negedge clk);
      checkOutput("b2b_mask_g0");
      applyStimulus(1'b1, 1'b0, 8'h11, 4'h0, 1'b1, 4'h1);
      @(negedge clk);
      checkOutput("b2b_mask_g1");
      applyStimulus(1'b1, 1'b0, 8'h12, 4'h0, 1'b1, 4'h0);
      @(negedge clk);
      checkOutput("b2b_mask_g2");
      bus_sel = 1'b0;

      // Asynchronous reset between clock edges
      access("mask_wr_g3", 1'b1, 1'b1, 8'h13, 4'hF, 1'b1, 4'h0);
      setEvents(16'h1000);
      setEvents(16'h0000);
      checkValue("irq_g3_set", 16'(interrupt_req), 16'h8);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 8'h13, 4'h0, 1'b1, 4'hF);
      @(posedge clk);
      #1;
      checkOutput("pre_reset_read");
      #2;
      reset_n = 1'b0;
      #1;
      checkValue("async_data", 16'(bus_read_data), 16'h0);
      checkValue("async_hit", 16'(bus_hit), 16'h0);
      checkValue("async_irq", 16'(interrupt_req), 16'h0);
      bus_sel = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      access("post_reset_factor", 1'b1, 1'b0, 8'h03, 4'h0, 1'b1, 4'h0);
      access("post_reset_mask", 1'b1, 1'b0, 8'h13, 4'h0, 1'b1, 4'h0);
      checkValue("post_reset_irq", 16'(interrupt_req), 16'h0);
      checkValue("queue_drained", 16'(expQueue.size()), 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
